// File: rtl/lin_comb_pkg.sv
// Shared types, constants and IEEE-754 double helpers for the linear-combination unit.
// Denormals are flushed to zero; overflow saturates to infinity; rounding is nearest-even.
package lin_comb_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, MUL, ADD, DONE} state_e;

    localparam int unsigned IDX_W       = 4;
    localparam int unsigned FP_W        = 64;
    localparam int unsigned FP_SIGN_BIT = 63;
    localparam logic [FP_W-1:0] FP_ZERO = 64'h0;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] man;
    } fp64_t;

    // Round a normalised fraction with guard/sticky bits and pack it.
    function automatic logic [63:0] fp_round_pack(input logic s, input logic signed [13:0] e,
                                                  input logic [51:0] f, input logic g,
                                                  input logic st);
        logic [52:0]        fr;
        logic signed [13:0] er;
        fr = {1'b0, f} + 53'(g & (st | f[0]));
        er = e;
        if (fr[52]) begin
            er = e + 14'sd1;
        end
        if (er >= 14'sd2047) begin
            return {s, 11'h7FF, 52'h0};
        end
        if (er <= 14'sd0) begin
            return {s, 63'h0};
        end
        return {s, er[10:0], fr[51:0]};
    endfunction

    function automatic logic [63:0] fp_mul(input fp64_t x, input fp64_t y);
        logic               s;
        logic [105:0]       p;
        logic signed [13:0] e;
        s = x.sign ^ y.sign;
        if (x.exp == 11'h0 || y.exp == 11'h0) begin
            return {s, 63'h0};
        end
        p = {53'h0, 1'b1, x.man} * {53'h0, 1'b1, y.man};
        e = $signed({3'b000, x.exp}) + $signed({3'b000, y.exp}) - 14'sd1023;
        if (p[105]) begin
            return fp_round_pack(s, e + 14'sd1, p[104:53], p[52], |p[51:0]);
        end
        return fp_round_pack(s, e, p[103:52], p[51], |p[50:0]);
    endfunction

    function automatic logic [63:0] fp_add(input fp64_t x, input fp64_t y);
        fp64_t              big;
        fp64_t              sml;
        logic [10:0]        d;
        logic [113:0]       sh;
        logic [56:0]        mb;
        logic [56:0]        ms;
        logic [56:0]        sum;
        logic signed [13:0] e;
        int                 lz;
        if (x.exp == 11'h0) begin
            return y;
        end
        if (y.exp == 11'h0) begin
            return x;
        end
        if (x[62:0] >= y[62:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        // Mantissas carry one overflow bit on top and guard/round/sticky below.
        d   = big.exp - sml.exp;
        mb  = {2'b01, big.man, 3'b000};
        sh  = {2'b01, sml.man, 3'b000, 57'h0} >> ((d > 11'd57) ? 11'd57 : d);
        ms  = {sh[113:58], sh[57] | (|sh[56:0])};
        sum = (big.sign == sml.sign) ? (mb + ms) : (mb - ms);
        if (sum == 57'h0) begin
            return FP_ZERO;
        end
        e = $signed({3'b000, big.exp});
        if (sum[56]) begin
            sum = {1'b0, sum[56:2], sum[1] | sum[0]};
            e   = e + 14'sd1;
        end else begin
            lz = 0;
            for (int k = 0; k <= 55; k++) begin
                if (sum[k]) begin
                    lz = 55 - k;
                end
            end
            sum = sum << lz;
            e   = e - $signed(14'(lz));
        end
        return fp_round_pack(big.sign, e, sum[54:3], sum[2], sum[1] | sum[0]);
    endfunction

endpackage

// File: rtl/lin_comb_unit_fpcore.sv
// Fixed-latency double multiplier/adder core: data_ready rises LAT cycles after in_ready.
// Held in reset whenever in_ready is low, so each use starts from a cleared state.
module lin_comb_unit_fpcore
    import lin_comb_pkg::*;
#(
    parameter bit          IS_MUL = 1'b1,
    parameter int unsigned LAT    = 11
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic            in_ready_i,
    input  logic [FP_W-1:0] op_a_i,
    input  logic [FP_W-1:0] op_b_i,
    output logic            data_ready_o,
    output logic [FP_W-1:0] result_o
);

    localparam int unsigned CNT_W = (LAT < 2) ? 1 : $clog2(LAT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dr_q, dr_d;
    logic [FP_W-1:0]  res_q, res_d;
    logic [FP_W-1:0]  result_c;

    generate
        if (IS_MUL) begin : g_mul
            assign result_c = fp_mul(op_a_i, op_b_i);
        end else begin : g_add
            assign result_c = fp_add(op_a_i, op_b_i);
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        dr_d  = dr_q;
        res_d = res_q;
        if (in_ready_i && !dr_q) begin
            if (cnt_q == CNT_W'(LAT - 1)) begin
                dr_d  = 1'b1;
                res_d = result_c;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
            dr_q  <= 1'b0;
            res_q <= FP_ZERO;
        end else begin
            cnt_q <= cnt_d;
            dr_q  <= dr_d;
            res_q <= res_d;
        end
    end

    assign data_ready_o = dr_q;
    assign result_o     = res_q;

endmodule

// File: rtl/lin_comb_unit.sv
// Sequential y = c +/- sum(a_i*b_i) over up to N_TERMS doubles, one shared
// multiplier and one shared adder core, strictly one operation at a time.
module lin_comb_unit
    import lin_comb_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned MUL_LAT = 11,
    parameter int unsigned ADD_LAT = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           n_terms,
    input  logic                 sub,
    input  logic [63:0]          c,
    input  logic [N_TERMS*64-1:0] a,
    input  logic [N_TERMS*64-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [63:0]          y,
    output logic                 start_err
);

    localparam logic [IDX_W-1:0] N_MAX = IDX_W'(N_TERMS);

    state_e               state_q, state_d;
    logic [FP_W-1:0]      c_q, c_d;
    logic [N_TERMS*64-1:0] a_q, a_d;
    logic [N_TERMS*64-1:0] b_q, b_d;
    logic                 sub_q, sub_d;
    logic [IDX_W-1:0]     n_q, n_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FP_W-1:0]      acc_q, acc_d;
    logic [FP_W-1:0]      prod_q, prod_d;
    logic                 mul_rdy_q, mul_rdy_d;
    logic                 add_rdy_q, add_rdy_d;
    logic [FP_W-1:0]      y_q, y_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic [IDX_W-1:0]     idx_next_c;
    logic [FP_W-1:0]      mul_a_c, mul_b_c;
    logic [FP_W-1:0]      mul_res_c, add_res_c;
    logic                 mul_dr_c, add_dr_c;
    logic                 mul_rst_c, add_rst_c;

    assign idx_next_c = idx_q + IDX_W'(1);
    assign mul_a_c    = a_q[64*int'(idx_q) +: 64];
    assign mul_b_c    = b_q[64*int'(idx_q) +: 64];
    assign mul_rst_c  = ~mul_rdy_q;
    assign add_rst_c  = ~add_rdy_q;

    lin_comb_unit_fpcore #(.IS_MUL(1'b1), .LAT(MUL_LAT)) u_mul (
        .clk          (clk),
        .reset_i      (mul_rst_c),
        .in_ready_i   (mul_rdy_q),
        .op_a_i       (mul_a_c),
        .op_b_i       (mul_b_c),
        .data_ready_o (mul_dr_c),
        .result_o     (mul_res_c)
    );

    lin_comb_unit_fpcore #(.IS_MUL(1'b0), .LAT(ADD_LAT)) u_add (
        .clk          (clk),
        .reset_i      (add_rst_c),
        .in_ready_i   (add_rdy_q),
        .op_a_i       (acc_q),
        .op_b_i       (prod_q),
        .data_ready_o (add_dr_c),
        .result_o     (add_res_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        n_d       = n_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        mul_rdy_d = mul_rdy_q;
        add_rdy_d = add_rdy_q;
        y_d       = y_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = start && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    c_d     = c;
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    n_d     = (n_terms > N_MAX) ? N_MAX : n_terms;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                acc_d = c_q;
                idx_d = '0;
                if (n_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d   = MUL;
                    mul_rdy_d = 1'b1;
                end
            end
            MUL: begin
                if (mul_dr_c) begin
                    prod_d              = mul_res_c;
                    prod_d[FP_SIGN_BIT] = mul_res_c[FP_SIGN_BIT] ^ sub_q;
                    mul_rdy_d           = 1'b0;
                    add_rdy_d           = 1'b1;
                    state_d             = ADD;
                end
            end
            ADD: begin
                if (add_dr_c) begin
                    acc_d     = add_res_c;
                    idx_d     = idx_next_c;
                    add_rdy_d = 1'b0;
                    if (idx_next_c < n_q) begin
                        state_d   = MUL;
                        mul_rdy_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                y_d     = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            c_q       <= FP_ZERO;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            n_q       <= '0;
            idx_q     <= '0;
            acc_q     <= FP_ZERO;
            prod_q    <= FP_ZERO;
            mul_rdy_q <= 1'b0;
            add_rdy_q <= 1'b0;
            y_q       <= FP_ZERO;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            mul_rdy_q <= mul_rdy_d;
            add_rdy_q <= add_rdy_d;
            y_q       <= y_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign y         = y_q;
    assign start_err = err_q;

endmodule

// File: doc/lin_comb_unit.md
LIN_COMB_UNIT -- requirements
Module: lin_comb_unit

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 4, meaning the maximum number of product terms (legal range 1..8).
REQ-002 The block SHALL have parameter MUL_LAT, default 11, meaning the multiplier core latency from in_ready to data_ready, in cycles.
REQ-003 The block SHALL have parameter ADD_LAT, default 14, meaning the adder core latency from in_ready to data_ready, in cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a computation, sampled only in IDLE.
REQ-007 The block SHALL have port n_terms, input, 4 bits: the number of active terms; values above N_TERMS are clamped to N_TERMS.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 gives y = c + sum(a_i*b_i); 1 gives y = c - sum(a_i*b_i).
REQ-009 The block SHALL have port c, input, 64 bits: IEEE-754 double offset.
REQ-010 The block SHALL have ports a and b, inputs, N_TERMS*64 bits each: packed doubles, with term i at bits [64i+63:64i].
REQ-011 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when y is updated.
REQ-013 The block SHALL have port y, output, 64 bits: result, held until the next done or reset.
REQ-014 The block SHALL have port start_err, output, 1 bit: one-cycle pulse when start is asserted while busy.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, MUL, ADD and DONE.
REQ-016 In IDLE with start=1, the block SHALL go to LOAD and register c, a, b, sub and the clamped n_terms.
REQ-017 In LOAD, the block SHALL set acc = c and term index i = 0, then go to DONE if n_terms = 0, else go to MUL.
REQ-018 In MUL, the block SHALL hold the multiplier in_ready high with operands a_i and b_i until data_ready, then capture the product, deassert in_ready and go to ADD.
REQ-019 When sub=1, the block SHALL invert the sign bit (bit 63) of the captured product; no other bit is altered.
REQ-020 In ADD, the block SHALL hold the adder in_ready high with operands acc and the product until data_ready, then set acc to the sum, increment i, and go to MUL if i < n_terms, else go to DONE.
REQ-021 Each core's reset SHALL be driven by the inverse of its in_ready, so every core is cleared between uses.
REQ-022 In DONE, the block SHALL set y = acc and pulse done for one cycle, then return to IDLE.
REQ-023 Latency from the start-sampling edge to the done pulse SHALL be exactly 2 + n*(MUL_LAT+ADD_LAT+2) cycles, where n is the clamped n_terms.
REQ-024 A start received while not in IDLE SHALL be ignored, shall leave the latched operands unchanged, and shall pulse start_err for one cycle.
REQ-025 A start held high through DONE SHALL be accepted in the IDLE cycle that follows; back-to-back operation is legal.
REQ-026 Inputs SHALL be don't-care except in the start-accept cycle.

Reset
REQ-027 While reset=1, the FSM SHALL go to IDLE and busy, done, start_err SHALL be 0, y SHALL be 0, acc SHALL be 0, i SHALL be 0, and both core in_ready signals SHALL be 0.
REQ-028 A reset during MUL or ADD SHALL abort the operation with no done pulse, and start SHALL be accepted on the first cycle after reset is released.
REQ-029 If reset and start are asserted in the same cycle, reset SHALL take priority.

Structure
REQ-030 Package lin_comb_pkg SHALL hold the state enum typedef, the term-index width, and the constants FP_SIGN_BIT=63 and FP_ZERO=64'h0.
REQ-031 The block SHALL instantiate exactly one double multiplier core and one double adder core, using the codebase's existing in_ready/data_ready/reset cores; no further sub-module is required.

Verification
REQ-032 The bench SHALL apply N_TERMS=1, n=1, sub=0, c=1.0 (3FF0000000000000), a=2.0 (4000000000000000), b=0.5 (3FE0000000000000) and require y=2.0 (4000000000000000) with done at exactly 2+MUL_LAT+ADD_LAT+2 cycles.
REQ-033 The bench SHALL apply n=3, c=1.0, pairs (2.0,2.0), (1.0,1.0), (0.5,2.0) and require y=7.0 (401C000000000000), busy high throughout, and a single done pulse.
REQ-034 The bench SHALL apply sub=1, n=1, c=5.0 (4014000000000000), a=b=2.0 and require y=1.0 (3FF0000000000000); it SHALL then apply n=0 with c=-1.0 (BFF0000000000000) and require y=BFF0000000000000 two cycles after start.
REQ-035 The bench SHALL pulse start mid-MUL with different operands and require a start_err pulse and an unchanged result; it SHALL also set n_terms=15 with N_TERMS=4 and require exactly 4 terms to be processed.
REQ-036 The bench SHALL assert reset during ADD of term 2 and require no done pulse and y=0, then require that a new start completes with the correct value.
